// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Drives an external 4-bit ripple ALU slice one nibble per cycle (low nibble
// first) so that it can carry out 4*NIB-bit ADD, SUB, AND, OR and SLT.
// Requests arrive over a valid/ready handshake. The carry is chained between
// passes. The assembled result, carry, overflow and error flag are returned
// over a second valid/ready handshake.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_op                : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5-7 illegal
//   req_a, req_b          : W-bit operands
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : W-bit result
//   rsp_cout, rsp_ovf     : final carry / signed overflow (arith ops only)
//   rsp_err               : illegal opcode flag
//   alu_a, alu_b, alu_cin : nibble operands and carry-in to the ALU
//   alu_signal            : ALU function select (32 ADD, 36 AND, 37 OR)
//   alu_out, alu_cout     : combinational ALU result, sampled same cycle
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int NIB = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [4*NIB-1:0]   req_a,
    input  logic [4*NIB-1:0]   req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [4*NIB-1:0]   rsp_data,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic               rsp_err,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [5:0]         alu_signal,
    output logic               alu_cin,
    input  logic [3:0]         alu_out,
    input  logic               alu_cout
);

    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;

    localparam logic [5:0] SIG_ADD = 6'd32;
    localparam logic [5:0] SIG_AND = 6'd36;
    localparam logic [5:0] SIG_OR  = 6'd37;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [KW-1:0]   r_k;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [W-1:0]    r_res;

    logic            r_rspValid;
    logic [W-1:0]    r_rspData;
    logic            r_rspCout;
    logic            r_rspOvf;
    logic            r_rspErr;

    logic            w_reqIsSub;
    logic            w_reqLegal;
    logic            w_isArith;
    logic            w_isLast;
    logic [KW+1:0]   w_bitIdx;
    logic [W-1:0]    w_resNext;
    logic            w_ovf;
    logic            w_sltBit;

    assign w_reqIsSub = (req_op == OP_SUB) || (req_op == OP_SLT);
    assign w_reqLegal = (req_op <= OP_SLT);
    assign w_isArith  = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_SLT);
    assign w_isLast   = (r_k == K_LAST);
    assign w_bitIdx   = {r_k, 2'b00};

    // Result with the current ALU nibble merged in; on the last pass this is
    // the complete result used for the overflow and SLT decisions.
    always_comb begin
        w_resNext = r_res;
        w_resNext[w_bitIdx +: 4] = alu_out;
    end

    // b was stored already inverted for SUB/SLT, so overflow is the plain
    // addition rule on a and b'.
    assign w_ovf    = (r_a[W-1] == r_b[W-1]) && (w_resNext[W-1] != r_a[W-1]);
    assign w_sltBit = w_resNext[W-1] ^ w_ovf;

    // Next-state logic.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_stateNext = w_reqLegal ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_isLast) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // ALU drive is combinational from state and nibble index; the ALU always
    // performs an add for the arithmetic ops.
    always_comb begin
        alu_a      = 4'd0;
        alu_b      = 4'd0;
        alu_signal = 6'd0;
        alu_cin    = 1'b0;
        if (r_state == S_RUN) begin
            alu_a = r_a[w_bitIdx +: 4];
            alu_b = r_b[w_bitIdx +: 4];
            if (w_isArith) begin
                alu_signal = SIG_ADD;
                alu_cin    = r_carry;
            end else if (r_op == OP_AND) begin
                alu_signal = SIG_AND;
            end else begin
                alu_signal = SIG_OR;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign rsp_cout  = r_rspCout;
    assign rsp_ovf   = r_rspOvf;
    assign rsp_err   = r_rspErr;

    // State, operand capture, nibble sequencing and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_op       <= 3'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_carry    <= 1'b0;
            r_res      <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspCout  <= 1'b0;
            r_rspOvf   <= 1'b0;
            r_rspErr   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= w_reqIsSub ? ~req_b : req_b;
                        r_op    <= req_op;
                        r_k     <= '0;
                        r_carry <= w_reqIsSub;
                        r_res   <= '0;
                        if (!w_reqLegal) begin
                            r_rspValid <= 1'b1;
                            r_rspData  <= '0;
                            r_rspCout  <= 1'b0;
                            r_rspOvf   <= 1'b0;
                            r_rspErr   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_res   <= w_resNext;
                    r_carry <= w_isArith & alu_cout;
                    if (w_isLast) begin
                        r_k        <= '0;
                        r_rspValid <= 1'b1;
                        r_rspData  <= (r_op == OP_SLT) ? {{(W-1){1'b0}}, w_sltBit} : w_resNext;
                        r_rspCout  <= w_isArith & alu_cout;
                        r_rspOvf   <= w_isArith & w_ovf;
                        r_rspErr   <= 1'b0;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
